// File: rtl/pong_score_ctrl.sv
// Score and match sequencer for pong: per-player BCD score, serve/point/hold flow,
// game-over detection and play gating for the ball/paddle stage.
module pong_score_ctrl #(
  parameter int unsigned SCORE_LIMIT = 9,
  parameter int unsigned HOLD_CLKS   = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Out_P1,
  input  logic       i_Out_P2,
  input  logic       i_Start,
  input  logic       i_Clear,
  output logic [3:0] o_Score_P1,
  output logic [3:0] o_Score_P2,
  output logic       o_Play_Enable,
  output logic       o_Point,
  output logic       o_Game_Over,
  output logic       o_Winner
);

  localparam int unsigned CNT_W = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0] LIMIT = 4'(SCORE_LIMIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       score_p1_r, score_p1_s;
  logic [3:0]       score_p2_r, score_p2_s;
  logic             winner_r, winner_s;
  logic             point_r, point_s;
  logic             play_en_r, game_over_r;
  logic             out_p1_d_r, out_p2_d_r, start_d_r;
  logic             rise_p1_s, rise_p2_s, rise_start_s;

  // Saturating increment keeps a digit from ever passing the match limit.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v < LIMIT) begin
      return v + 4'd1;
    end else begin
      return v;
    end
  endfunction

  assign rise_p1_s    = i_Out_P1 & ~out_p1_d_r;
  assign rise_p2_s    = i_Out_P2 & ~out_p2_d_r;
  assign rise_start_s = i_Start  & ~start_d_r;

  // Next-state, score and hold-counter logic; clear overrides every other event.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    score_p1_s = score_p1_r;
    score_p2_s = score_p2_r;
    winner_s   = winner_r;
    point_s    = 1'b0;
    if (i_Clear) begin
      state_s    = ST_IDLE;
      cnt_s      = '0;
      score_p1_s = 4'd0;
      score_p2_s = 4'd0;
      winner_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_start_s) begin
            state_s = ST_PLAY;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (rise_p1_s && rise_p2_s) begin
            // Simultaneous outs are treated as a replay: hold without scoring.
            state_s = ST_POINT;
            cnt_s   = '0;
          end else if (rise_p2_s) begin
            score_p1_s = sat_inc(score_p1_r);
            point_s    = 1'b1;
            if (score_p1_s == LIMIT) begin
              state_s  = ST_OVER;
              winner_s = 1'b0;
            end else begin
              state_s = ST_POINT;
              cnt_s   = '0;
            end
          end else if (rise_p1_s) begin
            score_p2_s = sat_inc(score_p2_r);
            point_s    = 1'b1;
            if (score_p2_s == LIMIT) begin
              state_s  = ST_OVER;
              winner_s = 1'b1;
            end else begin
              state_s = ST_POINT;
              cnt_s   = '0;
            end
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_POINT: begin
          if (cnt_r == CNT_LAST) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_OVER: begin
          state_s = ST_OVER;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // State, scores and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      score_p1_r  <= 4'd0;
      score_p2_r  <= 4'd0;
      winner_r    <= 1'b0;
      point_r     <= 1'b0;
      play_en_r   <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      score_p1_r  <= score_p1_s;
      score_p2_r  <= score_p2_s;
      winner_r    <= winner_s;
      point_r     <= point_s;
      play_en_r   <= (state_s == ST_PLAY);
      game_over_r <= (state_s == ST_OVER);
    end
  end

  // Previous-cycle copies of the inputs for rising-edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      out_p1_d_r <= 1'b0;
      out_p2_d_r <= 1'b0;
      start_d_r  <= 1'b0;
    end else begin
      out_p1_d_r <= i_Out_P1;
      out_p2_d_r <= i_Out_P2;
      start_d_r  <= i_Start;
    end
  end

  assign o_Score_P1    = score_p1_r;
  assign o_Score_P2    = score_p2_r;
  assign o_Play_Enable = play_en_r;
  assign o_Point       = point_r;
  assign o_Game_Over   = game_over_r;
  assign o_Winner      = winner_r;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Scoreboard bench for pong_score_ctrl: a rule-level match model predicts every cycle's
// outputs into a queue; a monitor pops and compares one entry per clock.
module tb_pong_score_ctrl;

  localparam int unsigned LIM  = 3;
  localparam int unsigned HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       out_p1 = 1'b0, out_p2 = 1'b0, start = 1'b0, clear = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       play_en, point, game_over, winner;

  always #5 clk = ~clk;

  pong_score_ctrl #(.SCORE_LIMIT(LIM), .HOLD_CLKS(HOLD)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Out_P1(out_p1), .i_Out_P2(out_p2),
    .i_Start(start), .i_Clear(clear), .o_Score_P1(score_p1), .o_Score_P2(score_p2),
    .o_Play_Enable(play_en), .o_Point(point), .o_Game_Over(game_over), .o_Winner(winner)
  );

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       pe;
    logic       pt;
    logic       go;
    logic       win;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Match model: ball in play, remaining hold cycles, match over, plus last input levels.
  int m_s1, m_s2, m_hold_left;
  bit m_in_play, m_over, m_win, m_prev1, m_prev2, m_prevs;

  function automatic exp_t model_step(bit rn, bit o1, bit o2, bit st, bit clr);
    exp_t e;
    bit r1, r2, rs, pt;
    pt = 1'b0;
    if (!rn) begin
      m_s1 = 0; m_s2 = 0; m_hold_left = 0;
      m_in_play = 1'b0; m_over = 1'b0; m_win = 1'b0;
      m_prev1 = 1'b0; m_prev2 = 1'b0; m_prevs = 1'b0;
    end else begin
      r1 = o1 && !m_prev1;
      r2 = o2 && !m_prev2;
      rs = st && !m_prevs;
      if (clr) begin
        m_s1 = 0; m_s2 = 0; m_hold_left = 0;
        m_in_play = 1'b0; m_over = 1'b0; m_win = 1'b0;
      end else if (m_in_play) begin
        if (r1 && r2) begin
          m_in_play = 1'b0;
          m_hold_left = HOLD;
        end else if (r1 || r2) begin
          pt = 1'b1;
          m_in_play = 1'b0;
          if (r2) m_s1 = m_s1 + 1;
          else    m_s2 = m_s2 + 1;
          if (m_s1 == LIM || m_s2 == LIM) begin
            m_over = 1'b1;
            m_win  = (m_s2 == LIM);
          end else begin
            m_hold_left = HOLD;
          end
        end
      end else if (m_hold_left > 0) begin
        m_hold_left = m_hold_left - 1;
      end else if (!m_over && rs) begin
        m_in_play = 1'b1;
      end
      m_prev1 = o1; m_prev2 = o2; m_prevs = st;
    end
    e.s1 = 4'(m_s1);
    e.s2 = 4'(m_s2);
    e.pe = m_in_play;
    e.pt = pt;
    e.go = m_over;
    e.win = m_win;
    return e;
  endfunction

  task automatic step(input bit rn, input bit o1, input bit o2, input bit st, input bit clr);
    @(negedge clk);
    rst_n = rn; out_p1 = o1; out_p2 = o2; start = st; clear = clr;
    exp_q.push_back(model_step(rn, o1, o2, st, clr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Serve, then deliver an out on the requested side and wait out any hold.
  task automatic serve_and_score(input bit to_p2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, to_p2, !to_p2, 1'b0, 1'b0);
    idle(HOLD + 3);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {score_p1, score_p2, play_en, point, game_over, winner};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got s1=%0d s2=%0d pe=%b pt=%b go=%b win=%b want s1=%0d s2=%0d pe=%b pt=%b go=%b win=%b",
                   $time, a.s1, a.s2, a.pe, a.pt, a.go, a.win, e.s1, e.s2, e.pe, e.pt, e.go, e.win);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t a;
    bit l1, l2, ls;
    // Reset then serve: play enabled after the start edge.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Out_P2 held for 10 cycles: one point to P1, then hold, then idle.
    repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(HOLD + 4);
    // Both outs rise together: replay hold, no point.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(HOLD + 4);
    // New match; P2 wins 0/3, then further edges are ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) serve_and_score(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Clear out of game over, then clear concurrent with a point edge.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    // P1 wins a match 3/0.
    repeat (3) serve_and_score(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Async reset in the middle of a point hold, off the clock edge.
    serve_and_score(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    a = {score_p1, score_p2, play_en, point, game_over, winner};
    n_cmp++;
    if (a !== '0) begin
      n_bad++;
      $display("FAIL async_reset got %h want 000", a);
    end
    a = model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomised play with held levels, rare clears and rare resets.
    l1 = 1'b0; l2 = 1'b0; ls = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) l1 = !l1;
      if ($urandom_range(0, 3) == 0) l2 = !l2;
      if ($urandom_range(0, 2) == 0) ls = !ls;
      step(($urandom_range(0, 399) != 0), l1, l2, ls, ($urandom_range(0, 59) == 0));
    end
    idle(2);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
